// File: rtl/conway_mode_controller.sv
// Sequencer for system_memory_v4: load seed, run generations, stream out.
// Optional ABORT input enabled by defining CONWAY_CTRL_ABORT_EN.
module conway_mode_controller #(
  parameter int DATA_SIZE = 5,
  parameter int GEN_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [GEN_WIDTH-1:0] GENERATIONS,
  input  logic                 HOST_DATA,
  input  logic                 HOST_VALID,
  output logic                 HOST_READY,
  input  logic                 OUT_READY,
  output logic                 OUT_VALID,
  output logic                 LOAD_MODE,
  output logic                 RUN_MODE,
  output logic                 OUTPUT_MODE,
  output logic                 SERIAL_IN,
  output logic                 BUSY,
  output logic                 DONE
`ifdef CONWAY_CTRL_ABORT_EN
  ,
  input  logic                 ABORT
`endif
);

  localparam int BW = $clog2(DATA_SIZE + 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_OUT,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [GEN_WIDTH-1:0] gen_q, gen_d;
  logic                 oval_q, oval_d;
  logic                 done_q, done_d;
  logic                 abort_w;

`ifdef CONWAY_CTRL_ABORT_EN
  assign abort_w = ABORT && (state_q != S_IDLE);
`else
  assign abort_w = 1'b0;
`endif

  assign SERIAL_IN = HOST_DATA;
  assign BUSY      = (state_q != S_IDLE);
  assign OUT_VALID = oval_q;
  assign DONE      = done_q;

  // Memory mode strobes; an aborting cycle must not disturb memory
  always_comb begin
    HOST_READY  = (state_q == S_LOAD) && !abort_w;
    LOAD_MODE   = HOST_READY && HOST_VALID;
    RUN_MODE    = (state_q == S_RUN) && !abort_w;
    OUTPUT_MODE = (state_q == S_OUT) && OUT_READY && !abort_w;
  end

  // Next-state: job sequencing and bit/generation counting
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gen_d   = gen_q;
    oval_d  = OUTPUT_MODE;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_LOAD;
          gen_d   = GENERATIONS;
          bit_d   = '0;
        end
      end
      S_LOAD: begin
        if (HOST_VALID) begin
          if (bit_q == LAST) begin
            bit_d   = '0;
            state_d = (gen_q != '0) ? S_RUN : S_OUT;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_RUN: begin
        gen_d = gen_q - GEN_WIDTH'(1);
        if (gen_q == GEN_WIDTH'(1)) begin
          state_d = S_OUT;
          bit_d   = '0;
        end
      end
      S_OUT: begin
        if (OUT_READY) begin
          if (bit_q == LAST) begin
            bit_d   = '0;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_w) begin
      state_d = S_IDLE;
      bit_d   = '0;
      gen_d   = '0;
      oval_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      gen_q   <= '0;
      oval_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      gen_q   <= gen_d;
      oval_q  <= oval_d;
      done_q  <= done_d;
    end
  end

endmodule
